write_s: RTL and testbench
==========================

WRITE_S -- requirements
Module: write_s

Interface
REQ-001 SHALL provide parameter DP_BASE, default 7'd64: DPRAM address of S element 0.
REQ-002 SHALL provide parameter SHIFT, default 16: arithmetic right shift applied to each S value before clipping.
REQ-003 SHALL have port CLOCK_50_I input 1: clock.
REQ-004 SHALL have port Resetn input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port WS_start input 1: level-sampled start request.
REQ-006 SHALL have port WS_done output 1: one-cycle completion pulse.
REQ-007 SHALL have port WS_busy output 1: high while an 8x8 block is in progress.
REQ-008 SHALL have port base_address input 18: SRAM word address of block pixel (0,0).
REQ-009 SHALL have port row_stride input 9: SRAM words per image row.
REQ-010 SHALL have port DP_read_address output 7: DPRAM read address.
REQ-011 SHALL have port DP_read_data input 32: signed S value, valid one cycle after its address.
REQ-012 SHALL have port SRAM_address output 18: SRAM write address.
REQ-013 SHALL have port SRAM_write_data output 16: packed pixel pair.
REQ-014 SHALL have port SRAM_we_n output 1: SRAM write enable, active-low.

Function
REQ-015 SHALL implement states S_WS_IDLE, S_WS_READ, S_WS_DRAIN and S_WS_DONE.
REQ-016 SHALL in S_WS_IDLE, on WS_start=1 at edge 0, latch base_address and row_stride, clear the element counter and enter S_WS_READ.
REQ-017 SHALL in S_WS_READ, cycles 1..64, drive DP_read_address = DP_BASE + e for element e = cycle-1, raster order (row = e[5:3], column = e[2:0]).
REQ-018 SHALL leave S_WS_READ after element 63 is addressed and enter S_WS_DRAIN for cycles 65..66.
REQ-019 SHALL in S_WS_DRAIN drive DP_read_address constant at DP_BASE+63.
REQ-020 SHALL convert each S value as p = clip(S >>> SHIFT) to 8 bits unsigned: negative -> 0, >255 -> 255, else the low 8 bits.
REQ-021 SHALL register the even-column pixel, and when the odd-column pixel arrives, drive SRAM_write_data = {even[7:0], odd[7:0]}.
REQ-022 SHALL for write k = 0..31 drive SRAM_address = base + (k>>2)*row_stride + (k&3), modulo 2^18 with wrap-around permitted.
REQ-023 SHALL assert SRAM_we_n=0 for exactly one cycle per write, in cycles 4, 6, ..., 66: 32 writes, never back-to-back.
REQ-024 SHALL hold SRAM_we_n=1 in every other cycle, including all of S_WS_IDLE.
REQ-025 SHALL in S_WS_DONE (cycle 67) assert WS_done=1 for one cycle, then return to S_WS_IDLE.
REQ-026 SHALL drive WS_busy=1 from cycle 1 through cycle 67 inclusive and 0 otherwise.
REQ-027 SHALL ignore WS_start while WS_busy=1; latched base/stride SHALL NOT change mid-block.
REQ-028 SHALL, if WS_start=1 in the WS_done cycle, ignore it; a new block starts only when WS_start is sampled in S_WS_IDLE (earliest cycle 68).
REQ-029 SHALL use a 9x18 multiply or an accumulated row offset for the address calculation; the result is identical either way, truncated to 18 bits.

Reset
REQ-030 SHALL on Resetn=0 immediately set: state S_WS_IDLE, WS_done=0, WS_busy=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, DP_read_address=DP_BASE, all counters and latches 0.
REQ-031 SHALL on reset mid-block abandon the block, issue no further writes and not resume after Resetn returns to 1.
REQ-032 SHALL require WS_start to be sampled anew in S_WS_IDLE after reset before any activity.

Verification
REQ-033 SHALL verify basic conversion: S[e] = (e*4)<<16, base=0, stride=160 -> 32 writes; write 0 = addr 0, data 16'h0004; write 5 = addr 161, data 16'h282C; WS_done at cycle 67.
REQ-034 SHALL verify clipping: S = 32'hFFFF0000 (-1.0) at even columns and 32'h01000000 (256.0) at odd columns -> every write data = 16'h00FF.
REQ-035 SHALL verify address wrap: base=18'h3FFFF, stride=80 -> write 1 = addr 18'h00000, write 4 = addr 18'h0004F.
REQ-036 SHALL verify start while busy: WS_start pulsed at cycles 10 and 67 -> exactly 32 writes, one WS_done, return to idle.
REQ-037 SHALL verify reset mid-block: Resetn=0 at cycle 30 -> SRAM_we_n=1, WS_busy=0 immediately, and no writes after reset until the next start.
REQ-038 SHALL verify back-to-back blocks: WS_start held high -> second block accepted at cycle 68, its first write at cycle 72, and 64 writes in total.

Source files
------------

// File: rtl/write_s.sv
// write_s: reads 64 S values of an 8x8 block from DPRAM, shifts and
// clips each to 8 bits, and writes 32 packed pixel pairs to SRAM.
// Ports: CLOCK_50_I/Resetn, WS_start/WS_done/WS_busy handshake,
// base_address/row_stride block placement, DP_read_* DPRAM port,
// SRAM_address/SRAM_write_data/SRAM_we_n SRAM write port.
module write_s #(
  parameter logic [6:0] DP_BASE = 7'd64,
  parameter int         SHIFT   = 16
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WS_start,
  output logic        WS_done,
  output logic        WS_busy,
  input  logic [17:0] base_address,
  input  logic [8:0]  row_stride,
  output logic [6:0]  DP_read_address,
  input  logic [31:0] DP_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [1:0] {
    S_WS_IDLE,
    S_WS_READ,
    S_WS_DRAIN,
    S_WS_DONE
  } ws_state_t;

  ws_state_t   state_q;
  logic [6:0]  cnt_q;
  logic [17:0] base_q;
  logic [8:0]  stride_q;
  logic [7:0]  even_q;

  logic [5:0]  elem;
  logic [31:0] shifted;
  logic [7:0]  pix;
  logic        pix_valid;
  logic [4:0]  wr_k;
  logic [11:0] row_off;
  logic [17:0] wr_addr;

  // cnt_q is the cycle number within the block; the data present in
  // cycle c belongs to element c-2 (one-cycle DPRAM latency).
  always_comb begin
    elem      = 6'(cnt_q - 7'd2);
    shifted   = 32'($signed(DP_read_data) >>> SHIFT);
    pix       = shifted[7:0];
    if (shifted[31])
      pix = 8'h00;
    else if (|shifted[30:8])
      pix = 8'hFF;
    pix_valid = (state_q == S_WS_READ || state_q == S_WS_DRAIN)
              && cnt_q >= 7'd2 && cnt_q <= 7'd65;
    wr_k      = elem[5:1];
    row_off   = 12'(wr_k[4:2]) * 12'(stride_q);
    wr_addr   = base_q + 18'(row_off) + 18'(wr_k[1:0]);
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_q         <= S_WS_IDLE;
      cnt_q           <= '0;
      base_q          <= '0;
      stride_q        <= '0;
      even_q          <= '0;
      WS_done         <= 1'b0;
      WS_busy         <= 1'b0;
      DP_read_address <= DP_BASE;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else begin
      SRAM_we_n <= 1'b1;
      WS_done   <= 1'b0;
      if (pix_valid) begin
        if (!elem[0]) begin
          even_q <= pix;
        end else begin
          SRAM_write_data <= {even_q, pix};
          SRAM_address    <= wr_addr;
          SRAM_we_n       <= 1'b0;
        end
      end
      unique case (state_q)
        S_WS_IDLE: begin
          if (WS_start) begin
            base_q          <= base_address;
            stride_q        <= row_stride;
            cnt_q           <= 7'd1;
            WS_busy         <= 1'b1;
            DP_read_address <= DP_BASE;
            state_q         <= S_WS_READ;
          end
        end
        S_WS_READ: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd64)
            state_q <= S_WS_DRAIN;
          else
            DP_read_address <= DP_BASE + cnt_q;
        end
        S_WS_DRAIN: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd66) begin
            WS_done <= 1'b1;
            state_q <= S_WS_DONE;
          end
        end
        S_WS_DONE: begin
          cnt_q   <= '0;
          WS_busy <= 1'b0;
          state_q <= S_WS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_s.sv
// tb_write_s: directed and randomized checks of write_s against a
// behavioural model of the block conversion and SRAM address pattern.
module tb_write_s;

  localparam int DPB = 64;

  logic        CLOCK_50_I = 1'b0;
  logic        Resetn = 1'b1;
  logic        WS_start = 1'b0;
  logic        WS_done;
  logic        WS_busy;
  logic [17:0] base_address = '0;
  logic [8:0]  row_stride = '0;
  logic [6:0]  DP_read_address;
  logic [31:0] DP_read_data = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  logic [31:0] mem [0:127];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t = 0;
  int          b2b = 0;
  logic        prev_we_n = 1'b1;
  int          wq_t [$];
  logic [17:0] wq_a [$];
  logic [15:0] wq_d [$];
  int          dq_t [$];
  logic        busy_log [0:4095];

  write_s dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .Resetn          (Resetn),
    .WS_start        (WS_start),
    .WS_done         (WS_done),
    .WS_busy         (WS_busy),
    .base_address    (base_address),
    .row_stride      (row_stride),
    .DP_read_address (DP_read_address),
    .DP_read_data    (DP_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  always @(posedge CLOCK_50_I) DP_read_data <= mem[DP_read_address];
  always @(posedge CLOCK_50_I) t++;

  always @(negedge CLOCK_50_I) begin
    if (t < 4096) busy_log[t] = WS_busy;
    if (!SRAM_we_n) begin
      wq_t.push_back(t);
      wq_a.push_back(SRAM_address);
      wq_d.push_back(SRAM_write_data);
      if (!prev_we_n) b2b++;
    end
    if (WS_done) dq_t.push_back(t);
    prev_we_n = SRAM_we_n;
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clip(input logic [31:0] s);
    longint v;
    v = longint'($signed(s)) / 65536;
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  function automatic logic [17:0] exp_addr(input int b, input int s,
                                           input int k);
    int a;
    a = (b + (k / 4) * s + (k % 4)) % 262144;
    return a[17:0];
  endfunction

  function automatic logic [15:0] exp_data(input int k);
    return {clip(mem[DPB + 2 * k]), clip(mem[DPB + 2 * k + 1])};
  endfunction

  task automatic clear_log();
    wq_t.delete();
    wq_a.delete();
    wq_d.delete();
    dq_t.delete();
  endtask

  task automatic wait_to(input int target);
    while (t < target) @(negedge CLOCK_50_I);
  endtask

  task automatic go(input logic [17:0] b, input logic [8:0] s,
                    output int t0);
    @(negedge CLOCK_50_I);
    clear_log();
    base_address = b;
    row_stride   = s;
    WS_start     = 1'b1;
    t0           = t;
    @(negedge CLOCK_50_I);
    WS_start     = 1'b0;
    base_address = ~b;
    row_stride   = ~s;
  endtask

  task automatic check_writes(input string nm, input int t0,
                              input int b, input int s,
                              input int first, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = first + k;
      if (i < wq_t.size()) begin
        chk($sformatf("%s_w%0d_addr", nm, k), wq_a[i], exp_addr(b, s, k));
        chk($sformatf("%s_w%0d_data", nm, k), wq_d[i], exp_data(k));
        chk($sformatf("%s_w%0d_cyc", nm, k), wq_t[i] - t0, 4 + 2 * k);
      end
    end
  endtask

  task automatic full_block(input string nm, input logic [17:0] b,
                            input logic [8:0] s);
    int t0;
    go(b, s, t0);
    wait_to(t0 + 72);
    chk({nm, "_nwrites"}, wq_t.size(), 32);
    check_writes(nm, t0, int'(b), int'(s), 0, 32);
    chk({nm, "_ndone"}, dq_t.size(), 1);
    if (dq_t.size() > 0) chk({nm, "_done_cyc"}, dq_t[0] - t0, 67);
    chk({nm, "_busy0"}, busy_log[t0], 0);
    chk({nm, "_busy1"}, busy_log[t0 + 1], 1);
    chk({nm, "_busy67"}, busy_log[t0 + 67], 1);
    chk({nm, "_busy68"}, busy_log[t0 + 68], 0);
  endtask

  initial begin
    int t0;
    logic [31:0] r;
    for (int i = 0; i < 128; i++) mem[i] = '0;

    #1 Resetn = 1'b0;
    #4;
    chk("rst_we_n", SRAM_we_n, 1);
    chk("rst_busy", WS_busy, 0);
    chk("rst_done", WS_done, 0);
    chk("rst_addr", SRAM_address, 0);
    chk("rst_wdata", SRAM_write_data, 0);
    chk("rst_dp_addr", DP_read_address, DPB);
    repeat (3) @(negedge CLOCK_50_I);
    Resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50_I);
    chk("idle_no_writes", wq_t.size(), 0);

    for (int e = 0; e < 64; e++) mem[DPB + e] = (e * 4) << 16;
    full_block("basic", 18'd0, 9'd160);
    if (wq_t.size() > 5) begin
      chk("basic_w0_addr_k", wq_a[0], 18'd0);
      chk("basic_w0_data_k", wq_d[0], 16'h0004);
      chk("basic_w5_addr_k", wq_a[5], 18'd161);
      chk("basic_w5_data_k", wq_d[5], 16'h282C);
    end

    for (int e = 0; e < 64; e++)
      mem[DPB + e] = e[0] ? 32'h0100_0000 : 32'hFFFF_0000;
    full_block("clip", 18'h00123, 9'd40);
    for (int i = 0; i < wq_d.size(); i++)
      chk($sformatf("clip_k%0d", i), wq_d[i], 16'h00FF);

    full_block("wrap", 18'h3FFFF, 9'd80);
    if (wq_t.size() > 4) begin
      chk("wrap_w1_addr_k", wq_a[1], 18'h00000);
      chk("wrap_w4_addr_k", wq_a[4], 18'h0004F);
    end

    for (int it = 0; it < 3; it++) begin
      for (int e = 0; e < 64; e++) begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0: mem[DPB + e] = r;
          1: mem[DPB + e] = {8'h00, r[7:0], r[31:16]};
          2: mem[DPB + e] = {16'hFFFF, r[15:0]};
          default: mem[DPB + e] = {15'h0000, r[16:0]} + 32'h00FF_8000;
        endcase
      end
      full_block($sformatf("rand%0d", it), 18'($urandom),
                 9'($urandom));
    end

    go(18'h01000, 9'd320, t0);
    wait_to(t0 + 10);
    WS_start = 1'b1;
    @(negedge CLOCK_50_I);
    WS_start = 1'b0;
    wait_to(t0 + 67);
    WS_start = 1'b1;
    @(negedge CLOCK_50_I);
    WS_start = 1'b0;
    wait_to(t0 + 140);
    chk("busy_start_nwrites", wq_t.size(), 32);
    check_writes("busy_start", t0, 32'h01000, 320, 0, 32);
    chk("busy_start_ndone", dq_t.size(), 1);
    chk("busy_start_idle68", busy_log[t0 + 68], 0);
    chk("busy_start_idle100", busy_log[t0 + 100], 0);

    go(18'h00200, 9'd64, t0);
    wait_to(t0 + 30);
    #2 Resetn = 1'b0;
    #1;
    chk("midrst_we_n", SRAM_we_n, 1);
    chk("midrst_busy", WS_busy, 0);
    @(negedge CLOCK_50_I);
    Resetn = 1'b1;
    wait_to(t0 + 130);
    chk("midrst_nwrites", wq_t.size(), 14);
    check_writes("midrst", t0, 32'h00200, 64, 0, 14);
    chk("midrst_ndone", dq_t.size(), 0);
    chk("midrst_busy_after", busy_log[t0 + 60], 0);

    @(negedge CLOCK_50_I);
    clear_log();
    base_address = 18'h20000;
    row_stride   = 9'd200;
    WS_start     = 1'b1;
    t0           = t;
    wait_to(t0 + 69);
    WS_start = 1'b0;
    wait_to(t0 + 150);
    chk("b2b_nwrites", wq_t.size(), 64);
    check_writes("b2b_a", t0, 32'h20000, 200, 0, 32);
    check_writes("b2b_b", t0 + 68, 32'h20000, 200, 32, 32);
    if (wq_t.size() > 32) chk("b2b_first2_cyc", wq_t[32] - t0, 72);
    chk("b2b_ndone", dq_t.size(), 2);
    chk("b2b_idle68", busy_log[t0 + 68], 0);
    chk("b2b_busy69", busy_log[t0 + 69], 1);

    chk("no_back_to_back_we", b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
